// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN defined), single-byte buffer with status flags,
// read over a picorv32-style wire-OR'ed memory bus selected by enable.
module uart_rx #(
   parameter int unsigned BAUD_DIVIDER = 868
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic        serialIn
);

   localparam logic [15:0] HalfBit = 16'(BAUD_DIVIDER / 2);
   localparam logic [15:0] FullBit = 16'(BAUD_DIVIDER);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_e;

   state_e      state_q, state_d;
   logic        sync_q, rxs_q;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  bit_count_q, bit_count_d;
   logic [7:0]  shifter_q, shifter_d;
   logic [7:0]  buffer_q, buffer_d;
   logic        full_q, full_d;
   logic        overrun_q, overrun_d;
   logic        framing_q, framing_d;
   logic        parity_q, parity_d;
   logic        deliver_q, deliver_d;
   logic        rdy_q;
   logic [31:0] rdata_q, rdata_d;

   logic        framing_set, parity_set, overrun_set;
   logic        act, is_read, rd_data, rd_status, wr_status;

   logic unused_bus;
   assign unused_bus = ^{mem_instr, mem_addr[31:3], mem_addr[1:0], mem_wdata[31:4], mem_wdata[0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q + 16'd1;
      bit_count_d = bit_count_q;
      shifter_d   = shifter_q;
      deliver_d   = 1'b0;
      framing_set = 1'b0;
      parity_set  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rxs_q) state_d = StStart;
         end
         StStart: begin
            // Half-bit wait puts every later sample in the middle of its bit.
            if (timer_q == HalfBit) begin
               if (!rxs_q) begin
                  state_d     = StData;
                  bit_count_d = 3'd0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (timer_q == FullBit) begin
               shifter_d   = {rxs_q, shifter_q[7:1]};
               bit_count_d = bit_count_q + 3'd1;
               timer_d     = 16'd0;
`ifdef UART_RX_PARITY_EN
               if (bit_count_q == 3'd7) state_d = StParity;
`else
               if (bit_count_q == 3'd7) state_d = StStop;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (timer_q == FullBit) begin
               parity_set = ^{shifter_q, rxs_q};
               state_d    = StStop;
            end
         end
`endif
         StStop: begin
            if (timer_q == FullBit) begin
               if (rxs_q) begin
                  deliver_d = 1'b1;
                  state_d   = StIdle;
               end else begin
                  framing_set = 1'b1;
                  state_d     = StBreak;
               end
            end
         end
         StBreak: begin
            if (rxs_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) timer_d = 16'd0;
   end

   assign act       = mem_valid & enable & ~rdy_q;
   assign is_read   = act & (mem_wstrb == 4'b0000);
   assign rd_data   = is_read & ~mem_addr[2];
   assign rd_status = is_read & mem_addr[2];
   assign wr_status = act & mem_wstrb[0] & mem_addr[2];

   always_comb begin
      buffer_d    = buffer_q;
      full_d      = full_q;
      overrun_set = 1'b0;
      // A DATA read in the delivery cycle takes the old byte, so the new one may replace it.
      if (deliver_q) begin
         if (!full_q || rd_data) begin
            buffer_d = shifter_q;
            full_d   = 1'b1;
         end else begin
            overrun_set = 1'b1;
         end
      end else if (rd_data) begin
         full_d = 1'b0;
      end

      overrun_d = overrun_set | (overrun_q & ~(wr_status & mem_wdata[1]));
      framing_d = framing_set | (framing_q & ~(wr_status & mem_wdata[2]));
      parity_d  = parity_set  | (parity_q  & ~(wr_status & mem_wdata[3]));

      rdata_d = rdata_q;
      if (rd_data) begin
         rdata_d = {23'b0, full_q, buffer_q};
      end else if (rd_status) begin
         rdata_d = {28'b0, parity_q, framing_q, overrun_q, full_q};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q      <= 1'b1;
         rxs_q       <= 1'b1;
         timer_q     <= 16'd0;
         bit_count_q <= 3'd0;
         shifter_q   <= 8'd0;
         buffer_q    <= 8'd0;
         full_q      <= 1'b0;
         overrun_q   <= 1'b0;
         framing_q   <= 1'b0;
         parity_q    <= 1'b0;
         deliver_q   <= 1'b0;
         rdy_q       <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         sync_q      <= serialIn;
         rxs_q       <= sync_q;
         timer_q     <= timer_d;
         bit_count_q <= bit_count_d;
         shifter_q   <= shifter_d;
         buffer_q    <= buffer_d;
         full_q      <= full_d;
         overrun_q   <= overrun_d;
         framing_q   <= framing_d;
         parity_q    <= parity_d;
         deliver_q   <= deliver_d;
         rdy_q       <= act;
         rdata_q     <= rdata_d;
      end
   end

   assign mem_ready = enable ? rdy_q : 1'b0;
   assign mem_rdata = enable ? rdata_q : 32'd0;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver, the receiving counterpart of the team's uartTx. It decodes the same 8-bit, LSB-first frame with 1 start bit, 8 data bits and stop bit(s), at a bit period of BAUD_DIVIDER+1 clocks. It holds one received byte plus status flags and exposes them on the same picorv32-style wire-OR'ed memory bus used by the TX block, selected by enable.

Parameters:
BAUD_DIVIDER, 868, bit period = BAUD_DIVIDER+1 clocks (115200 baud at 100 MHz); must be >= 7

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous, active-low reset
enable  input  1  chip select from address decoder
mem_valid  input  1  bus request
mem_ready  output  1  bus acknowledge; 0 when enable=0
mem_instr  input  1  unused
mem_wstrb  input  4  write strobes; 0 = read
mem_wdata  input  32  write data
mem_addr  input  32  bit 2 selects register: 0 = DATA, 1 = STATUS
mem_rdata  output  32  read data; 0 when enable=0
serialIn  input  1  asynchronous serial line, idle high

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; synchronizer flops=1; timer=0; bitCount=0; shifter=0; buffer=0.
  - bufferFull, overrun, framingError = 0; rdy=0; rdataReg=0.
  - Outputs: mem_ready=0, mem_rdata=0.
- Input sync: 2-flop synchronizer, giving a 2-cycle pin-to-logic latency. All decisions use the synced bit rxs.
- Timer: 16-bit counter, cleared on every state change.
- States:
  - IDLE: rxs=0 -> START.
  - START: at timer==BAUD_DIVIDER/2 (integer division), sample rxs.
    - rxs=0 -> DATA, bitCount=0.
    - rxs=1 -> IDLE (glitch rejected).
  - DATA: at timer==BAUD_DIVIDER, shifter <= {rxs, shifter[7:1]}, bitCount+1, timer=0. After the 8th bit -> STOP.
  - STOP: at timer==BAUD_DIVIDER, sample rxs.
    - rxs=1: deliver byte, then -> IDLE.
    - rxs=0: framingError=1, byte discarded, -> BREAK.
  - BREAK: wait for rxs=1, then -> IDLE. No start detection while in BREAK.
- Sampling point: because START waits a half bit, each later sample falls mid-bit. A second stop bit from the transmitter looks like idle and needs no handling.
- Deliver (one cycle, the cycle after the stop sample):
  - bufferFull=0: buffer<=shifter, bufferFull=1.
  - bufferFull=1 and no DATA read acting in the same cycle: overrun=1, buffer keeps the old byte, new byte dropped.
  - DATA read acting in the same cycle: the read captures the old byte; buffer<=new byte; bufferFull stays 1; overrun unchanged.
- Bus transactions:
  - act = mem_valid & enable & !rdy. A transaction's side effects happen exactly once, on its first cycle.
  - rdy <= act; mem_ready = enable ? rdy : 0, so mem_ready is high one cycle after mem_valid.
  - Read DATA: rdataReg <= {23'b0, bufferFull, buffer}; bufferFull cleared.
  - Read STATUS: rdataReg <= {28'b0, parityError, framingError, overrun, bufferFull}. No side effects.
  - Write STATUS with wstrb[0]=1: flags in bits [3:1] are cleared where mem_wdata bit = 1. bufferFull is not writable.
  - Write DATA: ignored; still acknowledged.
  - mem_rdata = enable ? rdataReg : 0.
  - A flag set and a write-1-clear of that flag in the same cycle: set wins.
- Reception continues regardless of bus activity.
- resetn deasserted mid-frame: resumes in IDLE and waits for the next falling edge.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: a parity bit follows the 8 data bits, with a PARITY state between DATA and STOP (sampled at timer==BAUD_DIVIDER). Even parity is expected.
  - Mismatch: parityError (STATUS bit 3) set, byte still delivered.
  - parityError is cleared by a write-1 to STATUS bit 3.
- Undefined: no PARITY state; STATUS bit 3 reads 0.

Test Plan:
1. Reset with serialIn=1 -> mem_ready=0, mem_rdata=0; STATUS read returns 0x0.
2. BAUD_DIVIDER=15 (16-clock bit); send 0xA5 with stop=1 -> STATUS reads 0x1; DATA read returns 0x1A5, mem_ready pulses 1 cycle after mem_valid; next STATUS read returns 0x0.
3. Send 0x3C then 0xC3 with no read in between -> STATUS 0x3; DATA reads 0x13C; write 0x2 to STATUS -> STATUS 0x0.
4. Send 0x55 with stop bit=0 held 3 bit-times -> STATUS 0x4, bufferFull=0. A new start edge arriving while the line is still low is ignored; the next valid frame 0x81 is received correctly.
5. 4-clock low glitch (< 8 = half bit at BAUD_DIVIDER=15) -> no state change beyond START, STATUS stays 0x0.
6. With 0x11 held in the buffer, time the DATA read to act in the same cycle as delivery of 0x22 -> read returns 0x111; following DATA read returns 0x122; overrun=0. With UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> STATUS 0x9.
